// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   Issue controller sitting between the EX stage and a multi-cycle
//   multiply/divide unit with HI/LO registers.  It launches MULT/DIV with
//   registered operands, issues one-cycle HI/LO writes for MTHI/MTLO, flags
//   MFHI/MFLO reads, and stalls EX and earlier while a multiply/divide
//   operation is in flight.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-high reset
//   valid_E   in   EX-stage instruction valid
//   op_E      in   EX op: 0 NONE, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5 MFHI,
//                  6 MFLO, 7 reserved (behaves as NONE)
//   rs_E      in   first operand from EX
//   rt_E      in   second operand from EX
//   busy      in   multiply/divide unit busy flag
//   A, B      out  registered operands to the multiply/divide unit
//   mult      out  one-cycle multiply start pulse
//   div       out  one-cycle divide start pulse
//   HIWrite   out  one-cycle HI write pulse (data on A)
//   LOWrite   out  one-cycle LO write pulse (data on A)
//   read      out  HI/LO read this cycle
//   sel_hi    out  1 = HI, 0 = LO; forced 0 when read = 0
//   stall     out  freeze EX and earlier stages
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_E,
    input  logic [2:0]        op_E,
    input  logic [DATA_W-1:0] rs_E,
    input  logic [DATA_W-1:0] rt_E,
    input  logic              busy,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              mult,
    output logic              div,
    output logic              HIWrite,
    output logic              LOWrite,
    output logic              read,
    output logic              sel_hi,
    output logic              stall
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        MTW   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic              mult_d;
    logic              div_d;
    logic              hi_d;
    logic              lo_d;
    logic              md_op;
    logic              is_read_op;

    // Only ops 1..6 involve the multiply/divide unit; NONE and the reserved
    // encoding fall through untouched.
    assign md_op      = valid_E && (op_E != OP_NONE) && (op_E != OP_RSVD);
    assign is_read_op = (op_E == OP_MFHI) || (op_E == OP_MFLO);

    // A stalled instruction is not consumed; it is simply re-presented and
    // re-evaluated once the FSM is back in IDLE.
    assign stall  = md_op && (state != IDLE);
    assign read   = md_op && (state == IDLE) && is_read_op;
    assign sel_hi = read && (op_E == OP_MFHI);

    always_comb begin
        state_d = state;
        a_d     = A;
        b_d     = B;
        mult_d  = 1'b0;
        div_d   = 1'b0;
        hi_d    = 1'b0;
        lo_d    = 1'b0;
        case (state)
            IDLE: begin
                if (md_op) begin
                    case (op_E)
                        OP_MULT: begin
                            a_d     = rs_E;
                            b_d     = rt_E;
                            mult_d  = 1'b1;
                            state_d = START;
                        end
                        OP_DIV: begin
                            a_d     = rs_E;
                            b_d     = rt_E;
                            div_d   = 1'b1;
                            state_d = START;
                        end
                        OP_MTHI: begin
                            a_d     = rs_E;
                            hi_d    = 1'b1;
                            state_d = MTW;
                        end
                        OP_MTLO: begin
                            a_d     = rs_E;
                            lo_d    = 1'b1;
                            state_d = MTW;
                        end
                        default: ;
                    endcase
                end
            end
            // The unit raises busy only after seeing the start pulse, so
            // START moves on unconditionally.
            START: state_d = WAIT;
            // The cycle that sees busy low still stalls: one bubble.
            WAIT:  if (!busy) state_d = IDLE;
            MTW:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            A       <= '0;
            B       <= '0;
            mult    <= 1'b0;
            div     <= 1'b0;
            HIWrite <= 1'b0;
            LOWrite <= 1'b0;
        end else begin
            state   <= state_d;
            A       <= a_d;
            B       <= b_d;
            mult    <= mult_d;
            div     <= div_d;
            HIWrite <= hi_d;
            LOWrite <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
//   Directed bench for md_issue_ctrl.  Every accepted MULT/DIV/MTHI/MTLO
//   pushes its expected pulse onto a queue; a negedge monitor pops and
//   checks each pulse the DUT emits.  Stall/read behaviour is checked
//   inline by the main sequence.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

    typedef struct packed {
        logic [1:0]  kind;   // 0 mult, 1 div, 2 HI write, 3 LO write
        logic [31:0] a;
        logic [31:0] b;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        valid_E;
    logic [2:0]  op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        busy;
    logic [31:0] A;
    logic [31:0] B;
    logic        mult;
    logic        div;
    logic        HIWrite;
    logic        LOWrite;
    logic        read;
    logic        sel_hi;
    logic        stall;

    int  n_cmp = 0;
    int  n_err = 0;
    sb_t sbq[$];

    md_issue_ctrl #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_E (valid_E),
        .op_E    (op_E),
        .rs_E    (rs_E),
        .rt_E    (rt_E),
        .busy    (busy),
        .A       (A),
        .B       (B),
        .mult    (mult),
        .div     (div),
        .HIWrite (HIWrite),
        .LOWrite (LOWrite),
        .read    (read),
        .sel_hi  (sel_hi),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        valid_E = v;
        op_E    = op;
        rs_E    = rs;
        rt_E    = rt;
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b);
        sb_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sbq.push_back(e);
    endtask

    // Called in the START cycle with a follow-on md op held in EX.
    // busy is high for n WAIT cycles, then low for one stalled cycle.
    task automatic run_wait(input int n, input string tag);
        chk({tag, "_start_stall"}, stall, 1);
        chk({tag, "_start_read"}, read, 0);
        tick();
        busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wait_stall"}, stall, 1);
            chk({tag, "_wait_read"}, read, 0);
            chk({tag, "_wait_nopulse"}, {30'd0, mult, div}, 0);
            tick();
        end
        busy = 1'b0;
        #1;
        chk({tag, "_bubble_stall"}, stall, 1);
        chk({tag, "_bubble_read"}, read, 0);
        tick();
    endtask

    // Pulse monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        sb_t         e;
        logic [1:0]  k;
        if (mult || div || HIWrite || LOWrite) begin
            chk("pulse_onehot", $countones({mult, div, HIWrite, LOWrite}), 1);
            k = mult ? 2'd0 : div ? 2'd1 : HIWrite ? 2'd2 : 2'd3;
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, k}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("sb_kind", {30'd0, k}, {30'd0, e.kind});
                chk("sb_A", A, e.a);
                if (k < 2'd2) chk("sb_B", B, e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        busy  = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_pulses", {28'd0, mult, div, HIWrite, LOWrite}, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // MULT 100*45, busy 5 cycles, MFHI queued behind it
        drive(1'b1, 3'd1, 32'd100, 32'd45);
        push(2'd0, 32'd100, 32'd45);
        #1;
        chk("mult_idle_stall", stall, 0);
        tick();
        chk("mult_pulse", mult, 1);
        chk("mult_A", A, 32'd100);
        chk("mult_B", B, 32'd45);
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        run_wait(5, "mult");
        chk("mult_idle_stall_after", stall, 0);
        chk("mult_mfhi_read", read, 1);
        chk("mult_mfhi_sel", sel_hi, 1);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        // DIV, MFLO held, busy 10 cycles
        drive(1'b1, 3'd2, 32'd1000, 32'd7);
        push(2'd1, 32'd1000, 32'd7);
        tick();
        chk("div_pulse", div, 1);
        chk("div_A", A, 32'd1000);
        drive(1'b1, 3'd6, 32'd0, 32'd0);
        run_wait(10, "div");
        chk("div_mflo_stall", stall, 0);
        chk("div_mflo_read", read, 1);
        chk("div_mflo_sel", sel_hi, 0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        // MTHI then MFHI, MTLO then MFLO
        drive(1'b1, 3'd3, 32'hDEAD_BEEF, 32'd0);
        push(2'd2, 32'hDEAD_BEEF, 32'd0);
        tick();
        chk("mthi_pulse", HIWrite, 1);
        chk("mthi_A", A, 32'hDEAD_BEEF);
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        #1;
        chk("mthi_mfhi_stall", stall, 1);
        chk("mthi_mfhi_read0", read, 0);
        tick();
        chk("mthi_clear", HIWrite, 0);
        chk("mthi_mfhi_go", stall, 0);
        chk("mthi_mfhi_read", read, 1);
        chk("mthi_mfhi_sel", sel_hi, 1);
        drive(1'b1, 3'd4, 32'h0000_1234, 32'd0);
        push(2'd3, 32'h0000_1234, 32'd0);
        tick();
        chk("mtlo_pulse", LOWrite, 1);
        drive(1'b1, 3'd6, 32'd0, 32'd0);
        #1;
        chk("mtlo_mflo_stall", stall, 1);
        tick();
        chk("mtlo_mflo_read", read, 1);
        chk("mtlo_mflo_sel", sel_hi, 0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        // Reset mid-WAIT with busy high
        drive(1'b1, 3'd1, 32'd7, 32'd9);
        push(2'd0, 32'd7, 32'd9);
        tick();
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        busy = 1'b1;
        tick();
        tick();
        chk("rw_wait_stall", stall, 1);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_A", A, 0);
        chk("rw_B", B, 0);
        chk("rw_pulses", {28'd0, mult, div, HIWrite, LOWrite}, 0);
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        #1;
        chk("rw_idle_stall", stall, 0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        busy  = 1'b0;
        // first edge after reset accepts
        drive(1'b1, 3'd1, 32'd11, 32'd22);
        push(2'd0, 32'd11, 32'd22);
        tick();
        chk("post_rst_mult", mult, 1);
        chk("post_rst_A", A, 32'd11);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        tick();

        // Non-ops: reserved op, invalid MULT, NONE; busy in IDLE ignored
        busy = 1'b1;
        drive(1'b1, 3'd7, 32'd1, 32'd2);
        #1;
        chk("rsvd_stall", stall, 0);
        chk("rsvd_read", read, 0);
        tick();
        chk("rsvd_pulses", {28'd0, mult, div, HIWrite, LOWrite}, 0);
        drive(1'b0, 3'd1, 32'd3, 32'd4);
        tick();
        chk("inval_pulses", {28'd0, mult, div, HIWrite, LOWrite}, 0);
        chk("inval_stall", stall, 0);
        chk("hold_A", A, 32'd11);
        chk("hold_B", B, 32'd22);
        drive(1'b1, 3'd0, 32'd5, 32'd6);
        tick();
        chk("none_pulses", {28'd0, mult, div, HIWrite, LOWrite}, 0);
        busy = 1'b0;

        // Back-to-back MULT
        drive(1'b1, 3'd1, 32'd3, 32'd4);
        push(2'd0, 32'd3, 32'd4);
        tick();
        chk("b2b_first", mult, 1);
        drive(1'b1, 3'd1, 32'd5, 32'd6);
        push(2'd0, 32'd5, 32'd6);
        run_wait(2, "b2b");
        chk("b2b_idle_stall", stall, 0);
        chk("b2b_not_yet", mult, 0);
        chk("b2b_A_held", A, 32'd3);
        tick();
        chk("b2b_second", mult, 1);
        chk("b2b_A2", A, 32'd5);
        chk("b2b_B2", B, 32'd6);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_E  in  1  the EX-stage instruction is valid.
- op_E  in  3  EX-stage operation: 0 NONE, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NONE).
- rs_E  in  32  first operand from EX stage.
- rt_E  in  32  second operand from EX stage.
- busy  in  1  multiply/divide unit busy flag.
- A  out  32  registered operand A to the multiply/divide unit.
- B  out  32  registered operand B to the multiply/divide unit.
- mult  out  1  one-cycle multiply start pulse.
- div  out  1  one-cycle divide start pulse.
- HIWrite  out  1  one-cycle HI write pulse; data on A.
- LOWrite  out  1  one-cycle LO write pulse; data on A.
- read  out  1  HI/LO read in the current cycle.
- sel_hi  out  1  1 selects HI and 0 selects LO, valid when read=1.
- stall  out  1  freezes the pipeline at EX and earlier.
REQ-002 Reset SHALL be asynchronous and active-high on port reset; the block SHALL have a single clock, clk.

Function
REQ-003 FSM states SHALL be IDLE, START, WAIT and MTW, with a 2-bit state register.
REQ-004 Define md_op = valid_E and op_E in 1..6. The block SHALL compute stall = md_op and (state != IDLE), combinationally.
REQ-005 An instruction SHALL be accepted in a cycle where the state is IDLE and md_op=1. No op is accepted in any other state.
REQ-006 Accept of MULT or DIV in IDLE SHALL do all of the following at the clock edge:
- A <= rs_E and B <= rt_E.
- the matching start register (mult or div) <= 1.
- state goes to START.
REQ-007 In START:
- exactly one of mult/div SHALL be high for this one cycle.
- at the next edge the start register clears and state goes to WAIT, regardless of busy.
REQ-008 In WAIT the state SHALL stay in WAIT while busy=1 and go to IDLE at the first edge where busy=0. The cycle in which busy=0 is observed still stalls, giving one bubble.
REQ-009 Accept of MTHI or MTLO in IDLE SHALL do all of the following at the clock edge:
- A <= rs_E.
- HIWrite or LOWrite (whichever matches) <= 1.
- state goes to MTW.
REQ-010 MTW SHALL last exactly one cycle with the write pulse high, then the pulse clears and state goes to IDLE. A following MFHI/MFLO is stalled during MTW, so it reads the written value.
REQ-011 MFHI or MFLO in IDLE SHALL not change state:
- read = 1 combinationally in that cycle.
- sel_hi = 1 for MFHI and 0 for MFLO.
- stall = 0.
REQ-012 When read is 0, sel_hi SHALL be 0.
REQ-013 read SHALL be 0 whenever stall=1.
REQ-014 op_E = 0, op_E = 7, or valid_E = 0 SHALL cause no state change and no output pulses.
REQ-015 busy asserted while the state is IDLE SHALL be ignored; the block holds no state about it.
REQ-016 A and B SHALL hold their last value when no accept occurs.
REQ-017 At most one of mult, div, HIWrite and LOWrite SHALL be high in any cycle.
REQ-018 A change of op_E while stalled SHALL have no effect. The pending op is re-evaluated in the first IDLE cycle.

Reset
REQ-019 While reset=1, independent of clk, the block SHALL hold:
- state = IDLE.
- A = 0 and B = 0.
- mult, div, HIWrite and LOWrite = 0.
REQ-020 Reset in any state, including START or WAIT with busy=1, SHALL abort to IDLE with no further pulses issued.
REQ-021 After reset deasserts, the first rising edge SHALL be able to accept an op.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- MULT, rs_E=100, rt_E=45, busy high for 5 cycles starting the cycle after the mult pulse -> mult=1 for exactly 1 cycle with A=100 and B=45; stall=1 from START through the cycle busy falls; IDLE on the next edge.
- DIV, then MFLO held in EX, busy high for 10 cycles -> div=1 for 1 cycle; read=0 throughout the stall; read=1 with sel_hi=0 in the first IDLE cycle.
- MTHI rs_E=32'hDEADBEEF, then MFHI -> HIWrite=1 for 1 cycle with A=32'hDEADBEEF; MFHI stalled 1 cycle; then read=1 with sel_hi=1.
- Reset asserted mid-WAIT with busy=1 -> outputs zero immediately; state IDLE; no mult/div pulse afterwards.
- op_E=7 with valid_E=1, and op_E=1 with valid_E=0 -> no pulses and stall=0.
- Back-to-back MULT, MULT -> second mult pulse issued only after the first WAIT exits; no overlap of pulses.
